btn_conditioner: RTL and testbench



---
 rtl/btn_pkg.sv | 26 ++
 rtl/btn_channel.sv | 197 +++++++++++++++++++
 rtl/btn_conditioner.sv | 53 +++++
 tb/tb_btn_conditioner.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : btn_pkg
//  Description : Shared types and helpers for the push-button conditioner.
//  Revision    : 1.0  initial release
// ============================================================================
package btn_pkg;

  // Per-channel debounce / hold state
  typedef enum logic [2:0] {
    REL     = 3'd0,
    REL_CHK = 3'd1,
    PRS     = 3'd2,
    PRS_CHK = 3'd3,
    HLD     = 3'd4
  } btn_state_e;

  // Bits needed to hold 0..max_val inclusive, never less than one
  function automatic int cnt_w(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_channel.sv
`default_nettype none
// ============================================================================
//  Module      : btn_channel
//  Description : One button channel: synchroniser, polarity fix, debounce
//                FSM, press/release pulses, long-press and auto-repeat.
//  Revision    : 1.0  initial release
// ============================================================================
module btn_channel
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int HOLD_CYCLES     = 16777216,
  parameter int REPEAT_CYCLES   = 2097152
) (
  input  logic tclk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic hold,
  output logic evt
);

  localparam int DB_W   = cnt_w(DEBOUNCE_CYCLES);
  localparam int HOLD_W = cnt_w(HOLD_CYCLES);
  localparam int REP_W  = cnt_w(REPEAT_CYCLES);

  localparam logic              C_RELEASED  = (ACTIVE_LOW != 0);
  localparam logic [DB_W-1:0]   C_DEB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] C_HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] C_HOLD_MAX  = HOLD_W'(HOLD_CYCLES);
  localparam logic [REP_W-1:0]  C_REP_LAST  = REP_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_p;

  btn_state_e        r_state, nxt_state;
  logic [DB_W-1:0]   r_db, nxt_db;
  logic [HOLD_W-1:0] r_hold_cnt, nxt_hold_cnt;
  logic [REP_W-1:0]  r_rep, nxt_rep;
  logic              r_level, nxt_level;
  logic              r_hold, nxt_hold;
  logic              r_rise, nxt_rise;
  logic              r_fall, nxt_fall;
  logic              r_evt, nxt_evt;
  logic              w_accept, w_release;

  // Synchroniser chain; resets to the idle pin level so reset never looks like a press
  always_ff @(posedge tclk) begin
    if (rst) r_sync <= {SYNC_STAGES{C_RELEASED}};
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], raw};
  end

  assign w_p = r_sync[SYNC_STAGES-1] ^ C_RELEASED;

  // State, counters and registered outputs
  always_ff @(posedge tclk) begin
    if (rst) begin
      r_state    <= REL;
      r_db       <= '0;
      r_hold_cnt <= '0;
      r_rep      <= '0;
      r_level    <= 1'b0;
      r_hold     <= 1'b0;
      r_rise     <= 1'b0;
      r_fall     <= 1'b0;
      r_evt      <= 1'b0;
    end else begin
      r_state    <= nxt_state;
      r_db       <= nxt_db;
      r_hold_cnt <= nxt_hold_cnt;
      r_rep      <= nxt_rep;
      r_level    <= nxt_level;
      r_hold     <= nxt_hold;
      r_rise     <= nxt_rise;
      r_fall     <= nxt_fall;
      r_evt      <= nxt_evt;
    end
  end

  // Next-state logic; hold/repeat timing runs while the debounced level is 1,
  // including bounce checks, so a short glitch never shifts hold or repeat ticks
  always_comb begin
    nxt_state    = r_state;
    nxt_db       = r_db;
    nxt_hold_cnt = r_hold_cnt;
    nxt_rep      = r_rep;
    nxt_level    = r_level;
    nxt_hold     = r_hold;
    nxt_rise     = 1'b0;
    nxt_fall     = 1'b0;
    nxt_evt      = 1'b0;
    w_accept     = 1'b0;
    w_release    = 1'b0;

    if (r_state == PRS || r_state == HLD || r_state == PRS_CHK) begin
      if (!r_hold) begin
        if (r_hold_cnt == C_HOLD_LAST) begin
          nxt_hold_cnt = C_HOLD_MAX;
          nxt_hold     = 1'b1;
          nxt_evt      = 1'b1;
          nxt_rep      = '0;
        end else begin
          nxt_hold_cnt = r_hold_cnt + 1'b1;
        end
      end else if (REPEAT_CYCLES > 0) begin
        if (r_rep == C_REP_LAST) begin
          nxt_rep = '0;
          nxt_evt = 1'b1;
        end else begin
          nxt_rep = r_rep + 1'b1;
        end
      end
    end

    case (r_state)
      REL: begin
        if (w_p) begin
          if (DEBOUNCE_CYCLES == 1) begin
            w_accept = 1'b1;
          end else begin
            nxt_state = REL_CHK;
            nxt_db    = DB_W'(1);
          end
        end
      end
      REL_CHK: begin
        if (!w_p) begin
          nxt_state = REL;
          nxt_db    = '0;
        end else if (r_db == C_DEB_LAST) begin
          w_accept = 1'b1;
        end else begin
          nxt_db = r_db + 1'b1;
        end
      end
      PRS, HLD: begin
        if (!w_p) begin
          if (DEBOUNCE_CYCLES == 1) begin
            w_release = 1'b1;
          end else begin
            nxt_state = PRS_CHK;
            nxt_db    = DB_W'(1);
          end
        end else begin
          nxt_state = nxt_hold ? HLD : PRS;
        end
      end
      PRS_CHK: begin
        if (w_p) begin
          nxt_state = nxt_hold ? HLD : PRS;
          nxt_db    = '0;
        end else if (r_db == C_DEB_LAST) begin
          w_release = 1'b1;
        end else begin
          nxt_db = r_db + 1'b1;
        end
      end
      default: begin
        nxt_state = REL;
        nxt_db    = '0;
      end
    endcase

    if (w_accept) begin
      nxt_state    = PRS;
      nxt_db       = '0;
      nxt_hold_cnt = '0;
      nxt_rep      = '0;
      nxt_level    = 1'b1;
      nxt_rise     = 1'b1;
      nxt_evt      = 1'b1;
    end

    if (w_release) begin
      nxt_state    = REL;
      nxt_db       = '0;
      nxt_hold_cnt = '0;
      nxt_rep      = '0;
      nxt_level    = 1'b0;
      nxt_hold     = 1'b0;
      nxt_fall     = 1'b1;
      nxt_evt      = 1'b0;
    end
  end

  assign level = r_level;
  assign rise  = r_rise;
  assign fall  = r_fall;
  assign hold  = r_hold;
  assign evt   = r_evt;

endmodule
`default_nettype wire

// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : btn_conditioner
//  Description : N-channel push-button front end (reset button + joypad).
//                Each channel is conditioned independently; any_pressed is
//                the OR of all debounced levels.
//  Revision    : 1.0  initial release
// ============================================================================
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int NUM_BTNS        = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int HOLD_CYCLES     = 16777216,
  parameter int REPEAT_CYCLES   = 2097152
) (
  input  logic                tclk,
  input  logic                rst,
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic [NUM_BTNS-1:0] level,
  output logic [NUM_BTNS-1:0] rise,
  output logic [NUM_BTNS-1:0] fall,
  output logic [NUM_BTNS-1:0] hold,
  output logic [NUM_BTNS-1:0] evt,      // rise or auto-repeat tick, 1 cycle
  output logic                any_pressed
);

  // One independent conditioner per button pin
  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
    btn_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .ACTIVE_LOW     (ACTIVE_LOW),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_ch (
      .tclk (tclk),
      .rst  (rst),
      .raw  (btn_raw[i]),
      .level(level[i]),
      .rise (rise[i]),
      .fall (fall[i]),
      .hold (hold[i]),
      .evt  (evt[i])
    );
  end

  assign any_pressed = |level;

endmodule
`default_nettype wire

// File: tb/tb_btn_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btn_conditioner
//  Description : Self-checking bench for btn_conditioner with a cycle-level
//                behavioural reference model and directed sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_btn_conditioner;

  localparam int NB   = 2;
  localparam int SS   = 2;
  localparam int AL   = 1;
  localparam int DEB  = 4;
  localparam int HOLD = 10;
  localparam int REP  = 3;

  logic          tclk = 1'b0;
  logic          rst  = 1'b1;
  logic [NB-1:0] btn_raw = '1;
  logic [NB-1:0] level, rise, fall, hold, evt;
  logic          any_pressed;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  btn_conditioner #(
    .NUM_BTNS(NB), .SYNC_STAGES(SS), .ACTIVE_LOW(AL),
    .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
  ) dut (
    .tclk(tclk), .rst(rst), .btn_raw(btn_raw),
    .level(level), .rise(rise), .fall(fall), .hold(hold), .evt(evt),
    .any_pressed(any_pressed)
  );

  always #5 tclk = ~tclk;

  // ---------------- reference model ----------------
  // lvl: debounced level; run: consecutive samples disagreeing with lvl;
  // age: edges since press was accepted; o = {level,rise,fall,hold,evt}
  typedef struct packed {
    logic       lvl;
    logic       hld;
    int         run;
    int         age;
    logic [4:0] o;
  } mres_t;

  function automatic mres_t model_step(input logic p, input mres_t s);
    mres_t n;
    logic r, f, e;
    n = s; r = 1'b0; f = 1'b0; e = 1'b0;
    n.run = (p != s.lvl) ? s.run + 1 : 0;
    if (s.lvl) begin
      if (n.run >= DEB) begin
        n.lvl = 1'b0; n.hld = 1'b0; n.age = 0; n.run = 0; f = 1'b1;
      end else begin
        n.age = s.age + 1;
        if (n.age >= HOLD) begin
          n.hld = 1'b1;
          if (n.age == HOLD) e = 1'b1;
          else if (REP > 0 && ((n.age - HOLD) % REP) == 0) e = 1'b1;
        end
      end
    end else if (n.run >= DEB) begin
      n.lvl = 1'b1; n.run = 0; n.age = 0; r = 1'b1; e = 1'b1;
    end
    n.o = {n.lvl, r, f, n.hld, e};
    return n;
  endfunction

  logic [SS-1:0] m_sync [NB];
  mres_t         m_res  [NB];

  always @(posedge tclk) begin
    for (int ch = 0; ch < NB; ch++) begin
      if (rst) begin
        m_sync[ch] <= {SS{AL == 1}};
        m_res[ch]  <= '0;
      end else begin
        m_sync[ch] <= {m_sync[ch][SS-2:0], btn_raw[ch]};
        m_res[ch]  <= model_step(m_sync[ch][SS-1] ^ (AL == 1), m_res[ch]);
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    logic [NB-1:0] el, er, ef, eh, ee;
    @(posedge tclk);
    #1;
    if (chk_en) begin
      for (int ch = 0; ch < NB; ch++) begin
        el[ch] = m_res[ch].o[4];
        er[ch] = m_res[ch].o[3];
        ef[ch] = m_res[ch].o[2];
        eh[ch] = m_res[ch].o[1];
        ee[ch] = m_res[ch].o[0];
      end
      chk("model", 32'({level, rise, fall, hold, evt, any_pressed}),
                   32'({el, er, ef, eh, ee, |el}));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- glitch / debounce table ----------------
  typedef struct {
    int low_len;   // raw cycles ch0 held low
    int rise_at;   // expected tick of rise, 0 = none
    int fall_at;   // expected tick of fall, 0 = none
  } vec_t;

  vec_t tbl [6];

  initial begin
    int rise_seen, fall_seen, pct;

    tbl[0] = '{1, 0, 0};
    tbl[1] = '{2, 0, 0};
    tbl[2] = '{3, 0, 0};
    tbl[3] = '{4, 6, 10};
    tbl[4] = '{5, 6, 11};
    tbl[5] = '{9, 6, 15};

    // Reset with buttons released: outputs all zero, then stay quiet
    rst = 1'b1; btn_raw = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_en = 1'b1;
      chk("reset_outs", 32'({level, rise, fall, hold, evt, any_pressed}), 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_outs", 32'({level, rise, fall, hold, evt, any_pressed}), 0);
    end

    // Short and long pulses on ch0
    for (int v = 0; v < 6; v++) begin
      rise_seen = 0; fall_seen = 0;
      btn_raw[0] = 1'b0;
      for (int t = 1; t <= 30; t++) begin
        tick();
        if (t == tbl[v].low_len) btn_raw[0] = 1'b1;
        if (rise[0] && rise_seen == 0) rise_seen = t;
        if (fall[0] && fall_seen == 0) fall_seen = t;
      end
      chk("tbl_rise_at", rise_seen, tbl[v].rise_at);
      chk("tbl_fall_at", fall_seen, tbl[v].fall_at);
    end

    // Press latency, hold, repeat and release
    idle(5);
    btn_raw[0] = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("press_rise", rise[0], i == 6);
      chk("press_evt", evt[0], i == 6);
      chk("press_level", level[0], i == 6);
    end
    for (int j = 1; j <= 20; j++) begin
      tick();
      chk("hold_lvl", hold[0], j >= 10);
      chk("hold_evt", evt[0], j == 10 || j == 13 || j == 16 || j == 19);
    end
    btn_raw[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("rel_fall", fall[0], k == 6);
      chk("rel_hold", hold[0], k < 6);
      chk("rel_level", level[0], k < 6);
      chk("rel_norise", rise[0], 0);
    end

    // Reset while pressed: drop without fall, re-qualify afterwards
    idle(10);
    btn_raw[0] = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("rst_pre_rise", rise[0], i == 6);
    end
    idle(4);
    rst = 1'b1;
    tick();
    chk("rst_level", level[0], 0);
    chk("rst_nofall", fall[0], 0);
    rst = 1'b0;
    for (int m = 1; m <= 8; m++) begin
      tick();
      chk("rst_rerise", rise[0], m == 6);
      chk("rst_nofall2", fall[0], 0);
    end

    // Both channels together, ch1 bounces mid-hold
    btn_raw = 2'b11;
    idle(12);
    btn_raw = 2'b00;
    for (int t = 1; t <= 6; t++) begin
      tick();
      chk("dual_rise", rise, (t == 6) ? 2'b11 : 2'b00);
    end
    for (int j = 1; j <= 12; j++) begin
      tick();
      if (j == 4) btn_raw[1] = 1'b1;
      if (j == 6) btn_raw[1] = 1'b0;
      chk("dual_hold", hold, (j >= 10) ? 2'b11 : 2'b00);
      chk("dual_nofall", fall, 0);
      chk("dual_level", level, 2'b11);
    end
    btn_raw = 2'b11;
    idle(10);

    // Randomised traffic with varying bounce density and occasional reset
    for (int seg = 0; seg < 16; seg++) begin
      case ($urandom_range(0, 3))
        0: pct = 1;
        1: pct = 3;
        2: pct = 10;
        default: pct = 40;
      endcase
      for (int c = 0; c < 250; c++) begin
        for (int ch = 0; ch < NB; ch++)
          if ($urandom_range(0, 99) < pct) btn_raw[ch] = ~btn_raw[ch];
        rst = ($urandom_range(0, 799) == 0);
        tick();
      end
      rst = 1'b0;
    end
    rst = 1'b0;
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
